// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of an LSU access. Accepts one doubleword-aligned
//   load/store at a time. Stores are byte-masked and committed into an
//   internal word array at acceptance. The response (read data and error
//   flag) is presented a fixed LAT cycles after acceptance.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_wr                1 = store, 0 = load
//   req_addr              byte address (bits [2:0] ignored)
//   req_wdata/req_wmask   lane-aligned store data and byte enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             loaded word (0 for stores and errors)
//   rsp_err               access fell outside [BASE_ADDR, BASE_ADDR+8*DEPTH)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload stable until that
// edge. The consumer may raise or lower ready freely. req_ready is high
// only in IDLE, so a request is never accepted in the same cycle as a
// response handshake.
module dmem_responder #(
  parameter int              XLEN      = 64,
  parameter int              DEPTH     = 256,
  parameter logic [XLEN-1:0] BASE_ADDR = 64'h8000_0000,
  parameter int              LAT       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [7:0]      req_wmask,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  // WAIT runs for cnt+1 cycles, so preload LAT-2 to land RESP at LAT.
  localparam logic [3:0] CNT_INIT = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  // Word array; deliberately not reset so contents survive rst.
  logic [XLEN-1:0] mem_q [DEPTH];

  logic [XLEN-1:0] off;
  logic [XLEN-1:0] idx_full;
  logic [AW-1:0]   mem_idx;
  logic            in_range;
  logic            accept;
  logic            wr_en;

  // Address decode. The >= check excludes the wrapped offsets that occur
  // for addresses below BASE_ADDR.
  always_comb begin
    off      = req_addr - BASE_ADDR;
    idx_full = off >> 3;
    mem_idx  = idx_full[AW-1:0];
    in_range = (req_addr >= BASE_ADDR) && (idx_full < XLEN'(DEPTH));
    accept   = req_valid && (state_q == IDLE);
    wr_en    = accept && req_wr && in_range;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (in_range && !req_wr) ? mem_q[mem_idx] : '0;
          err_d   = !in_range;
          if (LAT == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Stores commit at acceptance, so a later load always sees them and a
  // reset after acceptance cannot undo them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_wmask[b]) begin
          mem_q[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services load/store requests from the pipeline LSU. It is the memory-side end of the LSU access: it accepts one doubleword-aligned request at a time, applies byte-masked writes to an internal 64-bit-word array, returns read data after a fixed, programmable latency, and flags out-of-range accesses. It gives an RTL target for the simulation DPI memory and lets the LSU's stall and handshake paths be exercised.

Parameters:
XLEN, 64, data and address width
DEPTH, 256, number of XLEN-bit words in the array (power of two)
BASE_ADDR, 64'h8000_0000, byte address of word 0
LAT, 2, cycles from request acceptance to response valid (legal range 1..15)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_wr  in  1  1 = store, 0 = load
req_addr  in  XLEN  byte address; bits [2:0] are ignored
req_wdata  in  XLEN  store data, already lane-aligned by the LSU
req_wmask  in  8  byte-enable mask for stores; bit i covers bits [8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  LSU accepts the response
rsp_rdata  out  XLEN  full 64-bit word read (loads); 0 for stores and errors
rsp_err  out  1  access was out of range

Behaviour:
- Reset is asynchronous and active-high: clk drives all state, and rst asynchronously clears the FSM and registers.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
- The memory array is not reset. Its contents survive rst.
- Address decode: off = req_addr - BASE_ADDR and idx = off[XLEN-1:3].
- in_range = (req_addr >= BASE_ADDR) && (idx < DEPTH).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted at an edge where req_valid && req_ready.
  - At acceptance, capture rdata = (in_range && !req_wr) ? mem[idx] : 0, and err = !in_range.
  - At acceptance, if req_wr && in_range, write each byte whose req_wmask bit is set to mem[idx]. Bytes with a clear mask bit are unchanged. A mask of 0 writes nothing but still gets a response.
  - An out-of-range store modifies nothing.
  - Next state: if LAT==1, go to RESP. Otherwise load cnt=LAT-2 and go to WAIT.
- WAIT:
  - req_ready=0 and rsp_valid=0.
  - If cnt==0, go to RESP. Otherwise cnt decrements.
- RESP:
  - rsp_valid=1, and rsp_rdata/rsp_err hold the captured values.
  - These outputs stay stable while rsp_ready=0, with no timeout.
  - On an edge with rsp_ready=1, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Latency: a request accepted at edge T has rsp_valid high starting the cycle after edge T+LAT-1, i.e. LAT cycles after acceptance.
- Throughput: at most one request is outstanding. The minimum period is LAT+1 cycles per access, because req_ready returns the cycle after the response handshake.
- No request is accepted in the same cycle as a response handshake; req_ready is 0 in RESP.
- Ordering: a load issued after a store to the same word returns the stored data. This follows because the write is committed at acceptance.
- req_valid while req_ready=0 is ignored. The requester must hold the request stable until it is accepted.
- A reset during WAIT or RESP aborts the access and drops the response. A store that was already accepted remains committed.
- Address arithmetic is unsigned. Wrap-around of req_addr - BASE_ADDR only occurs for req_addr < BASE_ADDR, and that case is excluded by the >= check.

Test Plan:
- Store then load: store addr 0x8000_0010, wdata 0x1122334455667788, mask 0xFF; then load the same address. The load returns 0x1122334455667788 with err=0, and rsp_valid rises exactly 2 cycles after each acceptance (LAT=2).
- Byte mask: start with the word at 0x8000_0008 = 0xFFFF_FFFF_FFFF_FFFF. Store wdata 0x0000_00AB_0000_0000, mask 0x10. A later load returns 0xFFFF_FFAB_FFFF_FFFF.
- Out of range: load 0x7FFF_FFF8 and load 0x8000_0800 (idx 256). Both give rsp_err=1 and rdata=0. A store to 0x8000_0800 leaves all words unchanged.
- Response backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid and rsp_rdata stay constant and req_ready stays 0. Release rsp_ready; req_ready=1 on the next cycle.
- Reset mid-access: assert rst while in WAIT during a load. rsp_valid never asserts and req_ready=1 immediately. A previously written word still reads back its old value.
- LAT=1 build: back-to-back requests held on req_valid are accepted every 2 cycles, each with rsp_valid 1 cycle after acceptance and rsp_ready tied high.
